dw_clr_seq_ctrl: RTL and testbench

//  Source-domain clear sequencer in front of a reset/clear synchronizer pair.

---
 rtl/dw_clr_seq_pkg.sv | 30 +++
 rtl/dw_clr_seq_tmr.sv | 42 ++++
 rtl/dw_clr_seq_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_dw_clr_seq_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dw_clr_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dw_clr_seq_pkg
// Brief    : Shared types and helpers for the clear sequencer (FSM states,
//            counter width helper, gap counter width).
// Revision : 1.0 - initial release
// ============================================================================
package dw_clr_seq_pkg;

   // Sequencer states; the one unused 3-bit code is recovered to ST_IDLE.
   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_ISSUE      = 3'd1,
      ST_WAIT_PROG  = 3'd2,
      ST_WAIT_CMPLT = 3'd3,
      ST_DONE       = 3'd4,
      ST_ABORT      = 3'd5,
      ST_GAP        = 3'd6
   } state_t;

   // Gap counter width; covers GAP_CYC up to 15.
   localparam int GAP_W = 4;

   // Width needed to hold the values 0..max_cyc inclusive.
   function automatic int cnt_w(input int max_cyc);
      return (max_cyc < 1) ? 1 : $clog2(max_cyc + 1);
   endfunction

endpackage : dw_clr_seq_pkg
`default_nettype wire

// File: rtl/dw_clr_seq_tmr.sv
`default_nettype none
// ============================================================================
// Module   : dw_clr_seq_tmr
// Brief    : Loadable saturating up-counter with an equality compare flag.
//            Loading restarts the count at zero; counting stops at SAT_VAL.
// Revision : 1.0 - initial release
// ============================================================================
module dw_clr_seq_tmr #(
   parameter int W       = 8,
   parameter int SAT_VAL = 255,
   parameter int CMP_VAL = 255
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_init_n,
   input  logic i_load,
   input  logic i_en,
   output logic o_hit
);

   localparam logic [W-1:0] c_sat = W'(SAT_VAL);
   localparam logic [W-1:0] c_cmp = W'(CMP_VAL);

   logic [W-1:0] r_cnt;

   // Count up while enabled, hold at the saturation value, restart on load.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (!i_init_n) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= '0;
      end else if (i_en && (r_cnt != c_sat)) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_hit = (r_cnt == c_cmp);

endmodule : dw_clr_seq_tmr
`default_nettype wire

// File: rtl/dw_clr_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dw_clr_seq_ctrl
// Brief    : Source-domain clear sequencer. Merges pending per-agent clear
//            requests into one clr_s pulse, follows the synchronizer's
//            in-progress/complete handshake with a timeout, and reports
//            per-agent completion or error.
// Revision : 1.0 - initial release
// ============================================================================
module dw_clr_seq_ctrl
   import dw_clr_seq_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int TMO_CYC = 255,
   parameter int GAP_CYC = 2
) (
   input  logic               clk_s,
   input  logic               rst_s_n,
   input  logic               init_s_n,
   input  logic [NUM_REQ-1:0] req,
   output logic [NUM_REQ-1:0] done,
   output logic               done_err,
   output logic               busy,
   output logic               err_sticky,
   output logic               clr_s,
   input  logic               clr_in_prog_s,
   input  logic               clr_cmplt_s
);

   localparam int c_tmo_w = cnt_w(TMO_CYC);

   state_t               r_state;
   logic [NUM_REQ-1:0]   r_pend;
   logic [NUM_REQ-1:0]   r_own;
   logic [NUM_REQ-1:0]   r_done;
   logic                 r_done_err;
   logic                 r_busy;
   logic                 r_err_sticky;
   logic                 r_clr_s;

   logic                 w_pend_any;
   logic                 w_tmo_load;
   logic                 w_tmo_en;
   logic                 w_tmo_hit;
   logic                 w_gap_hit;

   assign w_pend_any = |r_pend;
   assign w_tmo_load = (r_state == ST_ISSUE);
   assign w_tmo_en   = (r_state == ST_WAIT_PROG) || (r_state == ST_WAIT_CMPLT);

   // Timeout counter: restarts in ISSUE, saturates at TMO_CYC so it never wraps.
   dw_clr_seq_tmr #(
      .W       (c_tmo_w),
      .SAT_VAL (TMO_CYC),
      .CMP_VAL (TMO_CYC)
   ) u_tmo (
      .clk      (clk_s),
      .rst_n    (rst_s_n),
      .i_init_n (init_s_n),
      .i_load   (w_tmo_load),
      .i_en     (w_tmo_en),
      .o_hit    (w_tmo_hit)
   );

   generate
      if (GAP_CYC > 0) begin : g_gap
         logic w_gap_load;
         logic w_gap_en;

         assign w_gap_load = (r_state == ST_DONE) || (r_state == ST_ABORT);
         assign w_gap_en   = (r_state == ST_GAP);

         // Gap counter: starts at 0 on GAP entry, flags the last gap cycle.
         dw_clr_seq_tmr #(
            .W       (GAP_W),
            .SAT_VAL (GAP_CYC - 1),
            .CMP_VAL (GAP_CYC - 1)
         ) u_gap (
            .clk      (clk_s),
            .rst_n    (rst_s_n),
            .i_init_n (init_s_n),
            .i_load   (w_gap_load),
            .i_en     (w_gap_en),
            .o_hit    (w_gap_hit)
         );
      end else begin : g_no_gap
         // GAP is never entered, so the flag is irrelevant.
         assign w_gap_hit = 1'b1;
      end
   endgenerate

   // Pending-request accumulator; ISSUE hands every pending bit to the round
   // and keeps only requests arriving in that same cycle for the next one.
   always_ff @(posedge clk_s or negedge rst_s_n) begin
      if (!rst_s_n) begin
         r_pend <= '0;
      end else if (!init_s_n) begin
         r_pend <= '0;
      end else if (r_state == ST_ISSUE) begin
         r_pend <= req;
      end else begin
         r_pend <= r_pend | req;
      end
   end

   // Sequencer FSM with registered outputs; outputs are set on the edge that
   // enters the state they belong to, so they line up with the state.
   always_ff @(posedge clk_s or negedge rst_s_n) begin
      if (!rst_s_n) begin
         r_state      <= ST_IDLE;
         r_own        <= '0;
         r_done       <= '0;
         r_done_err   <= 1'b0;
         r_busy       <= 1'b0;
         r_err_sticky <= 1'b0;
         r_clr_s      <= 1'b0;
      end else if (!init_s_n) begin
         r_state      <= ST_IDLE;
         r_own        <= '0;
         r_done       <= '0;
         r_done_err   <= 1'b0;
         r_busy       <= 1'b0;
         r_err_sticky <= 1'b0;
         r_clr_s      <= 1'b0;
      end else begin
         // Pulse outputs default low each cycle.
         r_clr_s    <= 1'b0;
         r_done     <= '0;
         r_done_err <= 1'b0;

         case (r_state)
            ST_IDLE: begin
               // A foreign clear in progress holds off our issue.
               if (w_pend_any && !clr_in_prog_s) begin
                  r_state <= ST_ISSUE;
                  r_clr_s <= 1'b1;
                  r_busy  <= 1'b1;
               end
            end

            ST_ISSUE: begin
               r_own   <= r_pend;
               r_state <= ST_WAIT_PROG;
            end

            ST_WAIT_PROG: begin
               // Completion wins over both the progress flag and the timeout.
               if (clr_cmplt_s) begin
                  r_state <= ST_DONE;
                  r_done  <= r_own;
               end else if (clr_in_prog_s) begin
                  r_state <= ST_WAIT_CMPLT;
               end else if (w_tmo_hit) begin
                  r_state      <= ST_ABORT;
                  r_done       <= r_own;
                  r_done_err   <= 1'b1;
                  r_err_sticky <= 1'b1;
               end
            end

            ST_WAIT_CMPLT: begin
               if (clr_cmplt_s) begin
                  r_state <= ST_DONE;
                  r_done  <= r_own;
               end else if (w_tmo_hit) begin
                  r_state      <= ST_ABORT;
                  r_done       <= r_own;
                  r_done_err   <= 1'b1;
                  r_err_sticky <= 1'b1;
               end
            end

            ST_DONE, ST_ABORT: begin
               r_own <= '0;
               if (GAP_CYC == 0) begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
               end else begin
                  r_state <= ST_GAP;
               end
            end

            ST_GAP: begin
               if (w_gap_hit) begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
               end
            end

            default: begin
               r_state <= ST_IDLE;
               r_own   <= '0;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign done       = r_done;
   assign done_err   = r_done_err;
   assign busy       = r_busy;
   assign err_sticky = r_err_sticky;
   assign clr_s      = r_clr_s;

endmodule : dw_clr_seq_ctrl
`default_nettype wire

// File: tb/tb_dw_clr_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dw_clr_seq_ctrl
// Brief    : Directed self-checking bench for dw_clr_seq_ctrl
//            (NUM_REQ=4, TMO_CYC=255, GAP_CYC=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_dw_clr_seq_ctrl;

   logic       clk_s;
   logic       rst_s_n;
   logic       init_s_n;
   logic [3:0] req;
   logic [3:0] done;
   logic       done_err;
   logic       busy;
   logic       err_sticky;
   logic       clr_s;
   logic       clr_in_prog_s;
   logic       clr_cmplt_s;

   int n_tests = 0;
   int n_fail  = 0;

   dw_clr_seq_ctrl #(
      .NUM_REQ (4),
      .TMO_CYC (255),
      .GAP_CYC (2)
   ) u_dut (
      .clk_s         (clk_s),
      .rst_s_n       (rst_s_n),
      .init_s_n      (init_s_n),
      .req           (req),
      .done          (done),
      .done_err      (done_err),
      .busy          (busy),
      .err_sticky    (err_sticky),
      .clr_s         (clr_s),
      .clr_in_prog_s (clr_in_prog_s),
      .clr_cmplt_s   (clr_cmplt_s)
   );

   initial begin
      clk_s = 1'b0;
      forever #5 clk_s = ~clk_s;
   end

   // Advance one cycle; inputs set afterwards belong to the new cycle and
   // outputs read afterwards show the new cycle's registered values.
   task automatic tick();
      @(posedge clk_s);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst_s_n       = 1'b0;
      init_s_n      = 1'b1;
      req           = 4'b0000;
      clr_in_prog_s = 1'b0;
      clr_cmplt_s   = 1'b0;

      // Reset state
      #3;
      chk("rst_clr_s", clr_s, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_done_err", done_err, 0);
      chk("rst_err_sticky", err_sticky, 0);
      tick(); tick();
      rst_s_n = 1'b1;
      tick(); tick();

      // 1: single request, slow handshake
      tick(); req = 4'b0001;                         // t
      tick(); req = 4'b0000;                         // t+1
      chk("t1_clr_s_t1", clr_s, 0);
      tick();                                        // t+2 ISSUE
      chk("t1_clr_s_t2", clr_s, 1);
      chk("t1_busy_t2", busy, 1);
      tick();                                        // t+3
      chk("t1_clr_s_t3", clr_s, 0);
      tick();                                        // t+4
      tick(); clr_in_prog_s = 1'b1;                  // t+5
      tick(); tick(); tick();                        // t+8
      tick(); clr_in_prog_s = 1'b0; clr_cmplt_s = 1'b1; // t+9
      chk("t1_done_t9", done, 0);
      tick(); clr_cmplt_s = 1'b0;                    // t+10 DONE
      chk("t1_done", done, 4'b0001);
      chk("t1_done_err", done_err, 0);
      tick();                                        // t+11 GAP
      chk("t1_done_t11", done, 0);
      tick();                                        // t+12 GAP
      chk("t1_busy_t12", busy, 1);
      tick();                                        // t+13 IDLE
      chk("t1_busy_t13", busy, 0);

      // 2: merged requests, re-request while in flight, fast path
      tick(); req = 4'b1010;                         // a
      tick(); req = 4'b0000;                         // a+1
      tick();                                        // a+2
      chk("t2_clr_s_a2", clr_s, 1);
      tick(); clr_in_prog_s = 1'b1;                  // a+3
      tick(); req = 4'b0010;                         // a+4 WAIT_CMPLT
      tick(); req = 4'b0000; clr_cmplt_s = 1'b1;     // a+5
      tick(); clr_in_prog_s = 1'b0; clr_cmplt_s = 1'b0; // a+6 DONE
      chk("t2_done1", done, 4'b1010);
      tick();                                        // a+7 GAP
      tick();                                        // a+8 GAP
      chk("t2_clr_s_a8", clr_s, 0);
      tick();                                        // a+9 IDLE
      chk("t2_clr_s_a9", clr_s, 0);
      chk("t2_busy_a9", busy, 0);
      tick();                                        // a+10 ISSUE
      chk("t2_clr_s_a10", clr_s, 1);
      tick(); clr_in_prog_s = 1'b1; clr_cmplt_s = 1'b1; // a+11
      tick(); clr_in_prog_s = 1'b0; clr_cmplt_s = 1'b0; // a+12 DONE
      chk("t2_done2", done, 4'b0010);
      chk("t2_done2_err", done_err, 0);
      // 6a: stale completion during GAP and IDLE
      tick(); clr_cmplt_s = 1'b1;                    // a+13 GAP
      tick(); clr_cmplt_s = 1'b0;                    // a+14 GAP
      chk("t6_gap_done", done, 0);
      chk("t6_gap_busy", busy, 1);
      tick();                                        // a+15 IDLE
      chk("t6_gap_exit", busy, 0);
      clr_cmplt_s = 1'b1;
      tick(); clr_cmplt_s = 1'b0;                    // a+16
      chk("t6_idle_done", done, 0);
      chk("t6_idle_busy", busy, 0);
      tick();
      chk("t6_idle_clr_s", clr_s, 0);

      // 3: silent synchronizer -> timeout
      tick(); req = 4'b0100;                         // b
      tick(); req = 4'b0000;                         // b+1
      tick();                                        // b+2
      chk("t3_clr_s", clr_s, 1);
      tick();                                        // b+3 WAIT_PROG, tmo=0
      repeat (255) tick();                           // b+258, tmo=255
      chk("t3_done_pre", done, 0);
      chk("t3_busy_pre", busy, 1);
      tick();                                        // b+259 ABORT
      chk("t3_done", done, 4'b0100);
      chk("t3_done_err", done_err, 1);
      chk("t3_err_sticky", err_sticky, 1);
      tick();                                        // b+260 GAP
      chk("t3_done_after", done, 0);
      chk("t3_done_err_after", done_err, 0);
      chk("t3_sticky_hold", err_sticky, 1);
      tick(); tick();                                // b+262 IDLE
      chk("t3_busy_end", busy, 0);

      // 4: foreign clear holds off issue
      tick(); clr_in_prog_s = 1'b1; req = 4'b0001;   // f
      tick(); req = 4'b0000;                         // f+1
      tick(); tick(); tick(); tick();                // f+5
      chk("t4_clr_s_held", clr_s, 0);
      chk("t4_busy_held", busy, 0);
      tick(); clr_in_prog_s = 1'b0;                  // f+6
      chk("t4_clr_s_f6", clr_s, 0);
      tick();                                        // f+7 ISSUE
      chk("t4_clr_s_f7", clr_s, 1);
      chk("t4_sticky", err_sticky, 1);
      tick(); clr_in_prog_s = 1'b1; clr_cmplt_s = 1'b1; // f+8
      tick(); clr_in_prog_s = 1'b0; clr_cmplt_s = 1'b0; // f+9 DONE
      chk("t4_done", done, 4'b0001);
      chk("t4_done_err", done_err, 0);
      tick(); tick(); tick();                        // f+12 IDLE

      // 5: asynchronous reset during WAIT_CMPLT
      tick(); req = 4'b1000;                         // h
      tick(); req = 4'b0000;                         // h+1
      tick();                                        // h+2 ISSUE
      tick(); clr_in_prog_s = 1'b1;                  // h+3
      tick(); req = 4'b0001;                         // h+4 WAIT_CMPLT
      tick(); req = 4'b0000;                         // h+5
      chk("t5_busy_pre", busy, 1);
      rst_s_n = 1'b0;
      #2;
      chk("t5_rst_busy", busy, 0);
      chk("t5_rst_clr_s", clr_s, 0);
      chk("t5_rst_done", done, 0);
      chk("t5_rst_sticky", err_sticky, 0);
      tick(); tick();
      rst_s_n = 1'b1; clr_in_prog_s = 1'b0;
      tick(); clr_cmplt_s = 1'b1;
      tick(); clr_cmplt_s = 1'b0;
      chk("t5_rel_done", done, 0);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("t5_lost_pend", {busy, clr_s}, 2'b00);
      end
      tick(); req = 4'b1000;                         // j
      tick(); req = 4'b0000;                         // j+1
      tick();                                        // j+2
      chk("t5_fresh_clr_s", clr_s, 1);
      tick(); clr_in_prog_s = 1'b1; clr_cmplt_s = 1'b1; // j+3
      tick(); clr_in_prog_s = 1'b0; clr_cmplt_s = 1'b0; // j+4 DONE
      chk("t5_fresh_done", done, 4'b1000);
      tick(); tick(); tick();

      // 6b: completion coincident with tmo==TMO_CYC -> DONE
      tick(); req = 4'b0010;                         // k
      tick(); req = 4'b0000;                         // k+1
      tick();                                        // k+2 ISSUE
      tick(); clr_in_prog_s = 1'b1;                  // k+3 WAIT_PROG tmo=0
      tick();                                        // k+4 WAIT_CMPLT tmo=1
      repeat (254) tick();                           // k+258 tmo=255
      chk("t6_coinc_pre", done, 0);
      clr_cmplt_s = 1'b1;
      tick(); clr_cmplt_s = 1'b0; clr_in_prog_s = 1'b0; // k+259 DONE
      chk("t6_coinc_done", done, 4'b0010);
      chk("t6_coinc_err", done_err, 0);
      chk("t6_coinc_sticky", err_sticky, 0);
      tick(); tick(); tick();

      // 7: timeout again, then synchronous init clears the sticky error
      tick(); req = 4'b0001;                         // l
      tick(); req = 4'b0000;
      tick(); tick();                                // l+3 WAIT_PROG
      repeat (255) tick();                           // l+258
      tick();                                        // l+259 ABORT
      chk("t7_done_err", done_err, 1);
      tick(); tick(); tick();                        // l+262 IDLE
      chk("t7_sticky_hold", err_sticky, 1);
      init_s_n = 1'b0;
      tick();
      init_s_n = 1'b1;
      chk("t7_init_sticky", err_sticky, 0);
      chk("t7_init_busy", busy, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_dw_clr_seq_ctrl
`default_nettype wire
